// File: rtl/seg7_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
// Holds the active-low glyph constants (bit order DP_A_B_C_D_E_F_G) and
// the per-slot state encoding used by seg7_scan_ctrl.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [7:0] SEG_DASH = 8'b11111110;

    // DP bit held high (off); the top level substitutes the real DP.
    localparam logic [7:0] GLYPH_0 = 8'b10000001;
    localparam logic [7:0] GLYPH_1 = 8'b11001111;
    localparam logic [7:0] GLYPH_2 = 8'b10010010;
    localparam logic [7:0] GLYPH_3 = 8'b10000110;
    localparam logic [7:0] GLYPH_4 = 8'b11001100;
    localparam logic [7:0] GLYPH_5 = 8'b10100100;
    localparam logic [7:0] GLYPH_6 = 8'b10100000;
    localparam logic [7:0] GLYPH_7 = 8'b10001111;
    localparam logic [7:0] GLYPH_8 = 8'b10000000;
    localparam logic [7:0] GLYPH_9 = 8'b10000100;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational digit decoder.
//   digit : 4-bit code, 0-9 decoded to the standard glyph, 10-15 to a dash
//   seg   : active-low DP_A_B_C_D_E_F_G pattern, DP always off (1)
module bcd_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = GLYPH_0;
            4'd1:    seg = GLYPH_1;
            4'd2:    seg = GLYPH_2;
            4'd3:    seg = GLYPH_3;
            4'd4:    seg = GLYPH_4;
            4'd5:    seg = GLYPH_5;
            4'd6:    seg = GLYPH_6;
            4'd7:    seg = GLYPH_7;
            4'd8:    seg = GLYPH_8;
            4'd9:    seg = GLYPH_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit gets a slot of REFRESH_DIV cycles; the first BLANK_CYC cycles of
// a slot turn every anode off to avoid ghosting. A new value is accepted by a
// valid/ready handshake into a pending register and only becomes visible at a
// frame boundary (digit 3 -> digit 0), so a frame never mixes two values.
//   clk, rst          : clock, synchronous active-high reset
//   load_valid/ready  : handshake for a new display value
//   load_data         : four 4-bit digits, [3:0] = digit 0 (rightmost)
//   load_dp           : decimal points, bit i = digit i
//   seg               : registered active-low DP_A_B_C_D_E_F_G
//   an                : registered active-low anodes, bit i = digit i
//   frame_tick        : one-cycle pulse in the first cycle after digit 3's slot
// Optional macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zeros on digits 3..1.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    output logic        load_ready,
    output logic [7:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    state_t        state_q, state_d;
    logic [15:0]   disp_q, pend_q;
    logic [3:0]    disp_dp_q, pend_dp_q;
    logic          pend_vld_q;
    logic [7:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          tick_q;

    logic          slot_end, frame_end, handshake;
    logic [3:0]    cur_digit;
    logic [7:0]    dec_seg;
    logic [3:0]    lz;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == 2'd3);
    // Ready is simply "nothing pending", so a second offer cannot overwrite.
    assign handshake = load_valid && !pend_vld_q;
    assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (disp_q[15:12] == 4'd0);
        lz[2] = lz[3] && (disp_q[11:8] == 4'd0);
        lz[1] = lz[2] && (disp_q[7:4] == 4'd0);
    end
`else
    assign lz = 4'b0000;
`endif

    // Slot counter, digit index and state; state follows the counter value.
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        state_d = (cnt_d < BLANK_LIM) ? BLANK : DRIVE;
    end

    // Output pattern for the current counter/index, registered below.
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = 4'b1111;
        if (state_q == DRIVE) begin
            an_d = ~(4'b0001 << idx_q);
            // dec_seg[7] is always 1, so the AND just inserts the active-low DP.
            if (lz[idx_q]) begin
                seg_d = {dec_seg[7] & ~disp_dp_q[idx_q], 7'h7F};
            end else begin
                seg_d = {dec_seg[7] & ~disp_dp_q[idx_q], dec_seg[6:0]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            state_q    <= BLANK;
            disp_q     <= 16'h0000;
            disp_dp_q  <= 4'h0;
            pend_q     <= 16'h0000;
            pend_dp_q  <= 4'h0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_OFF;
            an_q       <= 4'b1111;
            tick_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            tick_q  <= frame_end;
            // Only a value already pending moves at the boundary; one captured
            // on the boundary edge itself waits for the next frame.
            if (frame_end && pend_vld_q) begin
                disp_q    <= pend_q;
                disp_dp_q <= pend_dp_q;
            end
            if (handshake) begin
                pend_q     <= load_data;
                pend_dp_q  <= load_dp;
                pend_vld_q <= 1'b1;
            end else if (frame_end) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    assign load_ready = ~pend_vld_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic [3:0]  load_dp = 4'h0;
    logic        load_ready;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] prev_an = 4'hF;

    seg7_scan_ctrl #(
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLANK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 8'b10000001;
            4'd1:    return 8'b11001111;
            4'd2:    return 8'b10010010;
            4'd3:    return 8'b10000110;
            4'd4:    return 8'b11001100;
            4'd5:    return 8'b10100100;
            4'd6:    return 8'b10100000;
            4'd7:    return 8'b10001111;
            4'd8:    return 8'b10000000;
            4'd9:    return 8'b10000100;
            default: return 8'b11111110;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                           input int i);
        logic [3:0] d;
        logic [7:0] s;
        logic       blank;
        d     = v[i*4 +: 4];
        blank = LZB && (i > 0) && ((v >> (4 * i)) == 16'h0000);
        s     = blank ? 8'hFF : glyph(d);
        s[7]  = ~dp[i];
        return s;
    endfunction

    // Queue expected drive patterns for digits first..3 of a frame.
    task automatic push_digits(input logic [15:0] v, input logic [3:0] dp, input int first);
        exp_t       e;
        logic [3:0] a;
        for (int i = first; i < 4; i++) begin
            a     = 4'b0001 << i;
            e.an  = ~a;
            e.seg = exp_seg(v, dp, i);
            sb.push_back(e);
        end
    endtask

    // Scoreboard consumer: compare at the first drive cycle of each digit slot.
    always @(negedge clk) begin
        exp_t e;
        if (an !== 4'hF && prev_an === 4'hF && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg) begin
                errors++;
                $display("FAIL scoreboard_digit: got an=%b seg=%b, expected an=%b seg=%b",
                         an, seg, e.an, e.seg);
            end
        end
        prev_an <= an;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame_tick(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL frame_tick_timeout: frame_tick=%b after %0d cycles, expected 1", frame_tick, n);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        load_valid = 1'b0;
        tick();
        tick();
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", seg); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
        push_digits(16'h0000, 4'h0, 0);
        rst = 1'b0;
        tick();
        tick();
        checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL first_blank: got an=%b seg=%h expected 1111 ff", an, seg); end
        tick();
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL first_drive: got an=%b expected 1110", an); end
        wait_frame_tick(n);
        checks++; if (n != 29) begin errors++; $display("FAIL first_frame_len: got %0d expected 29", n); end
        wait_frame_tick(n);
        checks++; if (n != 32) begin errors++; $display("FAIL frame_period: got %0d expected 32", n); end
    endtask

    task automatic test_load_midframe();
        int n;
        bit hi;
        wait_frame_tick(n);
        repeat (4) tick();
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b expected 1", load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h1234;
        load_dp    = 4'b0100;
        tick();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ready_after_hs: got %b expected 0", load_ready); end
        push_digits(16'h0000, 4'h0, 1);  // old value finishes the frame
        n = 0;
        hi = 1'b0;
        do begin
            tick();
            n++;
            if (frame_tick !== 1'b1 && load_ready !== 1'b0) hi = 1'b1;
        end while (frame_tick !== 1'b1 && n < 40);
        checks++; if (hi) begin errors++; $display("FAIL ready_held_low: got ready=1 before frame_tick, expected 0"); end
        checks++; if (n != 27) begin errors++; $display("FAIL load_boundary_wait: got %0d expected 27", n); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL ready_at_tick: got %b expected 1", load_ready); end
        push_digits(16'h1234, 4'b0100, 0);
        wait_frame_tick(n);
    endtask

    task automatic test_dash_code();
        int n;
        load_valid = 1'b1;
        load_data  = 16'h00F7;
        load_dp    = 4'b0000;
        tick();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL dash_ready: got %b expected 0", load_ready); end
        push_digits(16'h1234, 4'b0100, 0);
        wait_frame_tick(n);
        push_digits(16'h00F7, 4'b0000, 0);
        wait_frame_tick(n);
    endtask

    task automatic test_back_to_back();
        int n;
        repeat (31) tick();
        checks++; if (frame_tick !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL pre_wrap: got tick=%b ready=%b expected 0 1", frame_tick, load_ready); end
        load_valid = 1'b1;
        load_data  = 16'h5555;
        load_dp    = 4'b0001;
        tick();
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL wrap_tick: got %b expected 1", frame_tick); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL wrap_capture: got ready=%b expected 0", load_ready); end
        load_data = 16'h9999;  // offered while not ready: must be ignored
        load_dp   = 4'b1111;
        push_digits(16'h00F7, 4'b0000, 0);
        repeat (5) tick();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready: got %b expected 0", load_ready); end
        wait_frame_tick(n);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL wrap_release: got %b expected 1", load_ready); end
        push_digits(16'h5555, 4'b0001, 0);
        wait_frame_tick(n);
    endtask

    task automatic test_reset_midslot();
        int n;
        tick();
        load_valid = 1'b1;
        load_data  = 16'h1234;
        load_dp    = 4'b1111;
        tick();
        load_valid = 1'b0;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL pend_before_rst: got %b expected 0", load_ready); end
        repeat (19) tick();
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL digit2_slot: got an=%b expected 1011", an); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL rst_outputs: got an=%b seg=%h expected 1111 ff", an, seg); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", load_ready); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", frame_tick); end
        push_digits(16'h0000, 4'h0, 0);
        wait_frame_tick(n);
        checks++; if (n != 32) begin errors++; $display("FAIL rst_restart: got %0d expected 32", n); end
        push_digits(16'h0000, 4'h0, 0);  // pending value was discarded
        wait_frame_tick(n);
    endtask

    initial begin
        test_reset();
        test_load_midframe();
        test_dash_code();
        test_back_to_back();
        test_reset_midslot();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
